// File: rtl/cordic_butterfly_seq.sv
// Radix-2 butterfly: out1 = a + r, out2 = a - r, with r = (x2 + j*y2) * e^(j*zangle) from an iterative CORDIC.
// Optional macro BFLY_SCALE_EN halves each output (round-half-up) before saturation.
module cordic_butterfly_seq #(
    parameter int DW   = 16,
    parameter int AW   = 32,
    parameter int ITER = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] y2,
    input  logic signed [AW-1:0] zangle,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] xout1,
    output logic signed [DW-1:0] yout1,
    output logic signed [DW-1:0] xout2,
    output logic signed [DW-1:0] yout2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat
);
    localparam int XW = DW + 2;
    localparam int KW = DW + 1;
    localparam int PW = XW + KW;
    localparam int IW = $clog2(ITER);
    localparam int KI = $rtoi(0.607253 * (2.0 ** (DW - 1)) + 0.5);
    localparam logic signed [KW-1:0] KC   = KW'(KI);
    localparam logic signed [PW-1:0] KRND = PW'(1) <<< (DW - 2);
    localparam logic signed [AW-1:0] QTR  = AW'(1) <<< (AW - 2);
    localparam logic signed [XW-1:0] SMAX = XW'((1 << (DW - 1)) - 1);
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, ROT, COMP, OUT} state_t;

    state_t               state;
    logic [IW-1:0]        cnt;
    logic                 pre;
    logic signed [XW-1:0] xr, yr;
    logic signed [AW-1:0] zr;
    logic signed [DW-1:0] ax, ay;

    // arctan(2^-i) with 2^63 = pi, narrowed to the AW-bit binary angle
    function automatic logic signed [AW-1:0] atan_c(input logic [IW-1:0] i);
        logic [31:0] a;
        logic [63:0] t;
        case (int'(i))
            0:  a = 32'h20000000;
            1:  a = 32'h12E4051E;
            2:  a = 32'h09FB385B;
            3:  a = 32'h051111D4;
            4:  a = 32'h028B0D43;
            5:  a = 32'h0145D7E1;
            6:  a = 32'h00A2F61E;
            7:  a = 32'h00517C55;
            8:  a = 32'h0028BE53;
            9:  a = 32'h00145F2F;
            10: a = 32'h000A2F98;
            11: a = 32'h000517CC;
            12: a = 32'h00028BE6;
            13: a = 32'h000145F3;
            14: a = 32'h0000A2FA;
            15: a = 32'h0000517D;
            16: a = 32'h000028BE;
            17: a = 32'h0000145F;
            18: a = 32'h00000A30;
            19: a = 32'h00000518;
            20: a = 32'h0000028C;
            21: a = 32'h00000146;
            22: a = 32'h000000A3;
            23: a = 32'h00000051;
            default: a = 32'h0;
        endcase
        t = {a, 32'h0} >> (64 - AW);
        return AW'(t);
    endfunction

    function automatic logic signed [XW-1:0] scale_f(input logic signed [XW-1:0] v);
`ifdef BFLY_SCALE_EN
        logic signed [XW-1:0] t;
        t = v + XW'(1);
        return t >>> 1;
`else
        return v;
`endif
    endfunction

    // {saturated, clamped value}
    function automatic logic [DW:0] sat_f(input logic signed [XW-1:0] v);
        if (v > SMAX) return {1'b1, DW'(SMAX)};
        if (v < SMIN) return {1'b1, DW'(SMIN)};
        return {1'b0, DW'(v)};
    endfunction

    // Shifts round half-up so the per-iteration truncation error does not drift in one direction
    logic signed [XW-1:0] half, xs, ys;
    logic signed [AW-1:0] da;
    always_comb begin
        half = '0;
        if (cnt != '0) half = XW'(1) <<< (cnt - 1'b1);
        xs = (xr + half) >>> cnt;
        ys = (yr + half) >>> cnt;
        da = atan_c(cnt);
    end

    logic signed [PW-1:0] px, py;
    logic signed [XW-1:0] kx, ky;
    logic [DW:0]          s1x, s1y, s2x, s2y;
    always_comb begin
        px  = PW'(xr) * PW'(KC) + KRND;
        py  = PW'(yr) * PW'(KC) + KRND;
        kx  = XW'(px >>> (DW - 1));
        ky  = XW'(py >>> (DW - 1));
        s1x = sat_f(scale_f(XW'(ax) + kx));
        s1y = sat_f(scale_f(XW'(ay) + ky));
        s2x = sat_f(scale_f(XW'(ax) - kx));
        s2y = sat_f(scale_f(XW'(ay) - ky));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            xout1     <= '0;
            yout1     <= '0;
            xout2     <= '0;
            yout2     <= '0;
            cnt       <= '0;
            pre       <= 1'b0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            ax        <= '0;
            ay        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        ax       <= x1;
                        ay       <= y1;
                        xr       <= XW'(x2);
                        yr       <= XW'(y2);
                        zr       <= zangle;
                        pre      <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ROT;
                    end
                end
                ROT: begin
                    if (pre) begin
                        // Fold |z| > pi/2 into CORDIC range: negate vector, z -/+ pi is an MSB flip
                        pre <= 1'b0;
                        if (zr > QTR || zr < -QTR) begin
                            xr <= -xr;
                            yr <= -yr;
                            zr <= {~zr[AW-1], zr[AW-2:0]};
                        end
                    end else begin
                        if (zr[AW-1]) begin
                            xr <= xr + ys;
                            yr <= yr - xs;
                            zr <= zr + da;
                        end else begin
                            xr <= xr - ys;
                            yr <= yr + xs;
                            zr <= zr - da;
                        end
                        if (cnt == IW'(ITER - 1)) begin
                            cnt   <= '0;
                            state <= COMP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMP: begin
                    xout1     <= s1x[DW-1:0];
                    yout1     <= s1y[DW-1:0];
                    xout2     <= s2x[DW-1:0];
                    yout2     <= s2y[DW-1:0];
                    sat       <= s1x[DW] | s1y[DW] | s2x[DW] | s2y[DW];
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        sat       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_butterfly_seq.sv
// Self-checking bench for cordic_butterfly_seq: directed corner cases plus random operations against a real-valued model.
module tb_cordic_butterfly_seq;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int ITER = 16;
`ifdef BFLY_SCALE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam real PI   = 3.14159265358979323846;
    localparam int  SATX = (SH != 0) ? 30000 : 32767;
    localparam int  SATF = (SH != 0) ? 0 : 1;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic signed [DW-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [AW-1:0]        zangle = '0;
    logic                 in_valid = 1'b0, out_ready = 1'b0;
    logic                 in_ready, out_valid, sat;
    logic signed [DW-1:0] xout1, yout1, xout2, yout2;

    cordic_butterfly_seq #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
        .clock(clock), .reset_n(reset_n),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .zangle(zangle),
        .in_valid(in_valid), .in_ready(in_ready),
        .xout1(xout1), .yout1(yout1), .xout2(xout2), .yout2(yout2),
        .out_valid(out_valid), .out_ready(out_ready), .sat(sat)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int lat;
    int ro[4];
    bit rsat;

    task automatic chk(input string tag, input longint got, input longint exp, input int tol = 0);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic run_op(input int a, input int b, input int c, input int d,
                          input logic [AW-1:0] z, input bit noise, input int stall);
        int n;
        bit busy_ok, hold_ok;
        @(negedge clock);
        x1 = DW'(a); y1 = DW'(b); x2 = DW'(c); y2 = DW'(d); zangle = z;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("accept_delay", n, 0);
        @(posedge clock); #1;
        if (noise) begin
            x1 = DW'($urandom); y1 = DW'($urandom); x2 = DW'($urandom); y2 = DW'($urandom);
            zangle = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 4 * ITER) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, ITER + 2);
        chk("busy_in_ready", busy_ok, 1);
        ro[0] = xout1; ro[1] = yout1; ro[2] = xout2; ro[3] = yout2;
        rsat = sat;
        hold_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clock);
            if (!out_valid || in_ready || sat != rsat || xout1 != DW'(ro[0]) || yout1 != DW'(ro[1]) ||
                xout2 != DW'(ro[2]) || yout2 != DW'(ro[3]))
                hold_ok = 1'b0;
        end
        if (stall > 0) chk("stall_hold", hold_ok, 1);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("xfer_out_valid", out_valid, 0);
        chk("xfer_in_ready", in_ready, 1);
    endtask

    // Ideal butterfly in real arithmetic
    task automatic model(input int a, input int b, input int c, input int d, input logic [AW-1:0] z,
                         output real v0, output real v1, output real v2, output real v3);
        real th, rx, ry;
        th = $itor($signed(z)) * PI / (2.0 ** (AW - 1));
        rx = c * $cos(th) - d * $sin(th);
        ry = c * $sin(th) + d * $cos(th);
        v0 = (a + rx) / (2.0 ** SH);
        v1 = (b + ry) / (2.0 ** SH);
        v2 = (a - rx) / (2.0 ** SH);
        v3 = (b - ry) / (2.0 ** SH);
    endtask

    task automatic check_res(input string tg, input int a, input int b, input int c, input int d,
                             input logic [AW-1:0] z, input int tol);
        real v[4];
        real hi, lo;
        int e;
        bit any_sat, clear;
        hi = 32767.0;
        lo = -32768.0;
        model(a, b, c, d, z, v[0], v[1], v[2], v[3]);
        any_sat = 1'b0;
        clear = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (v[k] > hi || v[k] < lo) any_sat = 1'b1;
            if ((v[k] - hi < 8.0 && hi - v[k] < 8.0) || (v[k] - lo < 8.0 && lo - v[k] < 8.0)) clear = 1'b0;
            if (v[k] > hi) e = 32767;
            else if (v[k] < lo) e = -32768;
            else e = $rtoi(v[k] + ((v[k] >= 0.0) ? 0.5 : -0.5));
            chk($sformatf("%s_out%0d", tg, k), ro[k], e, tol);
        end
        if (clear) chk($sformatf("%s_sat", tg), rsat, any_sat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, b, c, d, lim;
        logic [AW-1:0] z;
        bit seen;

        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_xout1", xout1, 0);
        chk("rst_yout2", yout2, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_first_ready", in_ready, 1);

        // zangle = 0, with a 10-cycle output stall
        run_op(2000, 0, 1000, 0, 32'h0000_0000, 1'b0, 10);
        chk("z0_xout1", ro[0], 3000 / (1 << SH), 2);
        chk("z0_yout1", ro[1], 0, 2);
        chk("z0_xout2", ro[2], 1000 / (1 << SH), 2);
        chk("z0_yout2", ro[3], 0, 2);
        chk("z0_sat", rsat, 0);

        // +pi/2
        run_op(0, 0, 1000, 0, 32'h4000_0000, 1'b0, 0);
        chk("pi2_xout1", ro[0], 0, 2);
        chk("pi2_yout1", ro[1], 1000 / (1 << SH), 2);
        chk("pi2_xout2", ro[2], 0, 2);
        chk("pi2_yout2", ro[3], -1000 / (1 << SH), 2);

        // -pi
        run_op(0, 0, 1000, 0, 32'h8000_0000, 1'b0, 0);
        chk("mpi_xout1", ro[0], -1000 / (1 << SH), 2);
        chk("mpi_yout1", ro[1], 0, 2);
        chk("mpi_xout2", ro[2], 1000 / (1 << SH), 2);
        chk("mpi_yout2", ro[3], 0, 2);

        // overflow of the upper sum
        run_op(30000, 0, 30000, 0, 32'h0000_0000, 1'b0, 0);
        chk("big_xout1", ro[0], SATX, (SH != 0) ? 4 : 0);
        chk("big_xout2", ro[2], 0, 4);
        chk("big_sat", rsat, SATF);

        for (int t = 0; t < 40; t++) begin
            lim = (t < 20) ? 4095 : 32767;
            a = int'($urandom_range(2 * lim)) - lim;
            b = int'($urandom_range(2 * lim)) - lim;
            c = int'($urandom_range(2 * lim)) - lim;
            d = int'($urandom_range(2 * lim)) - lim;
            z = $urandom;
            if (t % 13 == 7) z = 32'h8000_0000;
            run_op(a, b, c, d, z, 1'b1, (t % 8 == 3) ? 3 : 0);
            check_res("rnd", a, b, c, d, z, 8);
        end

        // Reset in the middle of ROT aborts the operation
        @(negedge clock);
        x1 = 16'sd500; y1 = 16'sd0; x2 = 16'sd1000; y2 = 16'sd0; zangle = 32'h1000_0000;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("abort_busy", in_ready, 0);
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_xout1", xout1, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("abort_rel_ready", in_ready, 1);
        seen = 1'b0;
        repeat (ITER + 8) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);

        run_op(2000, 0, 1000, 0, 32'h0000_0000, 1'b0, 0);
        chk("post_xout1", ro[0], 3000 / (1 << SH), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
